// File: rtl/line_xfer_engine.sv
// line_xfer_engine: cache-line miss engine (optional victim write-back, then line fill).
// Define LINE_XFER_TIMEOUT_EN to add an 8-bit ack watchdog that aborts with err_o.
module line_xfer_engine #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic              victim_dirty_i,
   input  logic [ADDR_W-1:0] victim_addr_i,
   input  logic [LINE_W-1:0] victim_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [LINE_W-1:0] fill_data_o,
   output logic              err_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic              mem_ack_i,
   input  logic [LINE_W-1:0] mem_data_i
);
   typedef enum logic [2:0] {IDLE, WB, GAP, FILL, DONE} state_t;
   localparam logic [ADDR_W-1:0] LMASK = {{(ADDR_W-5){1'b1}}, 5'b0};
   state_t state_q, state_d;
   logic [ADDR_W-1:0] vaddr_q, faddr_q, addr_q;
   logic [LINE_W-1:0] vdata_q, data_q, fill_q;
   logic en_q, wr_q, busy_q, done_q, err_q;
   logic xfer, ack, tmo;
   assign xfer = (state_q == WB) || (state_q == FILL);
   // an ack only counts once the request is actually visible on the bus
   assign ack = xfer && en_q && mem_ack_i;
`ifdef LINE_XFER_TIMEOUT_EN
   logic [7:0] wd_q;
   assign tmo = xfer && en_q && !mem_ack_i && (wd_q == 8'd255);
   always_ff @(posedge clk_i) begin
      if (rst_i) wd_q <= '0;
      else if ((state_d == WB || state_d == FILL) && state_d != state_q) wd_q <= '0;
      else if (en_q && !mem_ack_i && wd_q != 8'd255) wd_q <= wd_q + 8'd1;
   end
`else
   assign tmo = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = req_i ? (victim_dirty_i ? WB : FILL) : IDLE;
         WB:      state_d = tmo ? IDLE : (ack ? GAP : WB);
         GAP:     state_d = FILL;
         FILL:    state_d = tmo ? IDLE : (ack ? DONE : FILL);
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         vaddr_q <= '0;
         faddr_q <= '0;
         vdata_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         fill_q  <= '0;
         en_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_i) begin
            vaddr_q <= victim_addr_i & LMASK;
            faddr_q <= req_addr_i & LMASK;
            vdata_q <= victim_data_i;
         end
         // bus outputs follow the state one cycle later, so enable drops the edge after ack
         en_q   <= xfer && !tmo;
         wr_q   <= (state_q == WB) && !tmo;
         if (state_q == WB) begin
            addr_q <= vaddr_q;
            data_q <= vdata_q;
         end else if (state_q == FILL) addr_q <= faddr_q;
         if (state_q == FILL && ack) fill_q <= mem_data_i;
         busy_q <= state_d != IDLE;
         done_q <= state_q == DONE;
         err_q  <= tmo;
      end
   end
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign fill_data_o  = fill_q;
   assign mem_enable_o = en_q;
   assign mem_write_o  = wr_q;
   assign mem_addr_o   = addr_q;
   assign mem_data_o   = data_q;
endmodule

// File: tb/tb_line_xfer_engine.sv
// tb_line_xfer_engine: directed self-checking bench for line_xfer_engine.
// Built with or without LINE_XFER_TIMEOUT_EN; the no-ack step checks whichever behaviour applies.
module tb_line_xfer_engine;
   logic clk = 1'b0;
   logic rst, req, dirty, ack, busy, done, err, en, wr;
   logic [31:0] req_addr, vaddr, addr;
   logic [255:0] vdata, mdata, fill, wdata;
   int errs = 0, checks = 0;
   always #5 clk = ~clk;
   line_xfer_engine dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr),
      .victim_dirty_i(dirty), .victim_addr_i(vaddr), .victim_data_i(vdata),
      .busy_o(busy), .done_o(done), .fill_data_o(fill), .err_o(err),
      .mem_enable_o(en), .mem_write_o(wr), .mem_addr_o(addr), .mem_data_o(wdata),
      .mem_ack_i(ack), .mem_data_i(mdata)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   initial begin
      int bad, err_at;
      rst = 1'b1; req = 1'b0; dirty = 1'b0; ack = 1'b0;
      req_addr = '0; vaddr = '0; vdata = '0; mdata = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_en", en, 0);
      chk("rst_wr", wr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_addr", addr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_fill", fill, 0);
      // spurious ack in IDLE
      ack = 1'b1; mdata = 256'hDEAD;
      tick();
      ack = 1'b0;
      tick();
      chk("spur_busy", busy, 0);
      chk("spur_en", en, 0);
      chk("spur_fill", fill, 0);
      // clean miss, ack sampled 10 cycles after enable rises
      req = 1'b1; req_addr = 32'h0000_0047; dirty = 1'b0;
      tick();
      req = 1'b0;
      chk("clean_busy", busy, 1);
      chk("clean_en_lag", en, 0);
      tick();
      chk("clean_en", en, 1);
      chk("clean_wr", wr, 0);
      chk("clean_addr", addr, 32'h0000_0040);
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (!en || done || addr !== 32'h40) bad++;
      end
      chk("clean_hold", bad, 0);
      ack = 1'b1; mdata = 256'hA5;
      tick();
      ack = 1'b0; mdata = '0;
      chk("clean_en_ackedge", en, 1);
      chk("clean_nodone_early", done, 0);
      tick();
      chk("clean_done12", done, 1);
      chk("clean_en_low", en, 0);
      chk("clean_fill", fill, 256'hA5);
      chk("clean_idle", busy, 0);
      tick();
      chk("clean_done_pulse", done, 0);
      chk("clean_fill_hold", fill, 256'hA5);
      // dirty miss: write-back 0x400/0x5, one gap cycle, fill from 0x000
      req = 1'b1; dirty = 1'b1; vaddr = 32'h0000_0400; vdata = 256'h5; req_addr = 32'h0;
      tick();
      req = 1'b0; dirty = 1'b0;
      tick();
      chk("wb_en", en, 1);
      chk("wb_wr", wr, 1);
      chk("wb_addr", addr, 32'h400);
      chk("wb_data", wdata, 256'h5);
      ack = 1'b1;
      tick();
      ack = 1'b1;
      chk("wb_en_ackedge", en, 1);
      tick();
      ack = 1'b0;
      chk("gap_en", en, 0);
      chk("gap_busy", busy, 1);
      tick();
      chk("fill_en", en, 1);
      chk("fill_wr", wr, 0);
      chk("fill_addr", addr, 32'h0);
      ack = 1'b1; mdata = 256'h3C;
      tick();
      ack = 1'b0;
      chk("dirty_nodone", done, 0);
      tick();
      chk("dirty_done", done, 1);
      chk("dirty_fill", fill, 256'h3C);
      tick();
      chk("dirty_single_done", done, 0);
      // req held high: one sequence per acceptance, re-accept only from IDLE
      req = 1'b1; req_addr = 32'h0000_0080;
      tick();
      tick();
      chk("hold_en", en, 1);
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (!en || wr || done) bad++;
      end
      chk("hold_no_requeue", bad, 0);
      ack = 1'b1; mdata = 256'h77;
      tick();
      ack = 1'b0;
      tick();
      chk("hold_done", done, 1);
      chk("hold_idle", busy, 0);
      tick();
      chk("hold_reaccept", busy, 1);
      chk("hold_reaccept_en", en, 0);
      chk("hold_done_once", done, 0);
      req = 1'b0;
      tick();
      ack = 1'b1; mdata = 256'h88;
      tick();
      ack = 1'b0;
      tick();
      chk("hold2_done", done, 1);
      chk("hold2_fill", fill, 256'h88);
      // reset mid write-back, then a stray ack
      req = 1'b1; dirty = 1'b1; vaddr = 32'h0000_0600; vdata = 256'h9;
      tick();
      req = 1'b0; dirty = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_en", en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_wr", wr, 0);
      chk("midrst_addr", addr, 0);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("stray_busy", busy, 0);
      chk("stray_en", en, 0);
      tick();
      chk("stray_done", done, 0);
      // reset wins over a simultaneous request
      req = 1'b1; rst = 1'b1;
      tick();
      req = 1'b0; rst = 1'b0;
      chk("rstreq_busy", busy, 0);
      tick();
      chk("rstreq_en", en, 0);
      // no ack ever
      req = 1'b1; req_addr = 32'h0000_1000;
      tick();
      req = 1'b0;
      tick();
      chk("noack_en", en, 1);
`ifdef LINE_XFER_TIMEOUT_EN
      err_at = 0;
      for (int i = 1; i <= 300; i++) begin
         tick();
         if (err) begin
            err_at = i;
            break;
         end
      end
      chk("tmo_err_at", err_at, 256);
      chk("tmo_en", en, 0);
      chk("tmo_busy", busy, 0);
      chk("tmo_done", done, 0);
      tick();
      chk("tmo_err_pulse", err, 0);
`else
      bad = 0;
      err_at = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (!busy || !en) bad++;
         if (err) err_at++;
      end
      chk("noack_busy1000", bad, 0);
      chk("noack_err", err_at, 0);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
